uart_line_editor: RTL and testbench

UART_LINE_EDITOR -- requirements
Module: uart_line_editor

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_line_buf.sv | 21 ++
 rtl/uart_line_editor.sv | 133 +++++++++++++
 tb/tb_uart_line_editor.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and character helpers for the UART line editor.
package uart_pkg;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;
  localparam logic [7:0] CHAR_SP    = 8'h20;
  localparam logic [7:0] CHAR_TILDE = 8'h7E;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_COLLECT = 2'd0;
  localparam logic [ST_W-1:0] ST_EMIT    = 2'd1;
  localparam logic [ST_W-1:0] ST_EMIT_CR = 2'd2;
  localparam logic [ST_W-1:0] ST_EMIT_LF = 2'd3;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_SP) && (c <= CHAR_TILDE);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if ((c >= 8'h61) && (c <= 8'h7A)) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/uart_line_buf.sv
// Line buffer: DEPTH x 8 register array, one synchronous write port, combinational read.
module uart_line_buf #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [7:0]               rdata_c_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_line_editor.sv
// Collects printable bytes into a line with backspace editing, then emits the
// line followed by CR/LF through a valid/ready handshake when CR is received.
module uart_line_editor
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter bit          UPPER = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_drop,
  output logic       o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ST_W-1:0] state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            drop_q, drop_d;
  logic            busy_q, busy_d;

  logic            buf_we;
  logic [7:0]      buf_wdata;
  logic [7:0]      buf_rdata_c;
  logic            xfer_c;

  assign xfer_c    = valid_q & i_ready;
  assign buf_wdata = UPPER ? to_upper(i_data) : i_data;

  uart_line_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i     (i_clk),
    .we_i      (buf_we),
    .waddr_i   (cnt_q[AW-1:0]),
    .wdata_i   (buf_wdata),
    .raddr_i   (rd_d),
    .rdata_c_o (buf_rdata_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      rd_q    <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, counters and drop detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    drop_d  = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (i_valid) begin
          if (is_printable(i_data)) begin
            if (cnt_q < CW'(DEPTH)) begin
              buf_we = 1'b1;
              cnt_d  = cnt_q + CW'(1);
            end else begin
              drop_d = 1'b1;
            end
          end else if ((i_data == CHAR_BS) || (i_data == CHAR_DEL)) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          end else if (i_data == CHAR_CR) begin
            rd_d    = '0;
            state_d = (cnt_q != '0) ? ST_EMIT : ST_EMIT_CR;
          end
        end
      end
      ST_EMIT: begin
        drop_d = i_valid;
        if (xfer_c) begin
          if (({1'b0, rd_q} + CW'(1)) == cnt_q) state_d = ST_EMIT_CR;
          else                                  rd_d    = rd_q + AW'(1);
        end
      end
      ST_EMIT_CR: begin
        drop_d = i_valid;
        if (xfer_c) state_d = ST_EMIT_LF;
      end
      ST_EMIT_LF: begin
        drop_d = i_valid;
        if (xfer_c) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
          rd_d    = '0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Registered output payload follows the next state; buffer is read at rd_d.
  always_comb begin
    valid_d = (state_d != ST_COLLECT);
    busy_d  = (state_d != ST_COLLECT);
    case (state_d)
      ST_EMIT:    data_d = buf_rdata_c;
      ST_EMIT_CR: data_d = CHAR_CR;
      ST_EMIT_LF: data_d = CHAR_LF;
      default:    data_d = 8'h00;
    endcase
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_drop  = drop_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_line_editor.sv
// Bench for uart_line_editor: two instances (DEPTH 32 and 4) share stimulus and are
// checked every cycle against a queue-based line model.
module tb_uart_line_editor;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] o_data_w  [2];
  logic       o_valid_w [2];
  logic       o_drop_w  [2];
  logic       o_busy_w  [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] line_m [2][$];
  logic [7:0] out_m  [2][$];
  bit         drop_m [2];
  int         dep    [2] = '{32, 4};

  always #5 clk = ~clk;

  uart_line_editor #(.DEPTH(32), .UPPER(1'b1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_data(o_data_w[0]), .o_valid(o_valid_w[0]), .i_ready(i_ready),
    .o_drop(o_drop_w[0]), .o_busy(o_busy_w[0])
  );

  uart_line_editor #(.DEPTH(4), .UPPER(1'b1)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_data(o_data_w[1]), .o_valid(o_valid_w[1]), .i_ready(i_ready),
    .o_drop(o_drop_w[1]), .o_busy(o_busy_w[1])
  );

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  // Line semantics: a line is a list of bytes; CR turns it into an output list.
  task automatic model_step(input int i, input bit rst, input bit v, input logic [7:0] d, input bit r);
    logic [7:0] c;
    drop_m[i] = 1'b0;
    if (rst) begin
      line_m[i].delete();
      out_m[i].delete();
    end else if (out_m[i].size() > 0) begin
      if (r) void'(out_m[i].pop_front());
      if (v) drop_m[i] = 1'b1;
    end else if (v) begin
      if (d >= 8'h20 && d <= 8'h7E) begin
        c = (d >= "a" && d <= "z") ? d - 8'h20 : d;
        if (line_m[i].size() < dep[i]) line_m[i].push_back(c);
        else drop_m[i] = 1'b1;
      end else if (d == 8'h08 || d == 8'h7F) begin
        if (line_m[i].size() > 0) void'(line_m[i].pop_back());
      end else if (d == 8'h0D) begin
        out_m[i] = line_m[i];
        out_m[i].push_back(8'h0D);
        out_m[i].push_back(8'h0A);
        line_m[i].delete();
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit r);
    i_rst = rst; i_valid = v; i_data = d; i_ready = r;
    for (int i = 0; i < 2; i++) model_step(i, rst, v, d, r);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("valid", i, 8'(o_valid_w[i]), 8'(out_m[i].size() > 0));
      chk("busy",  i, 8'(o_busy_w[i]),  8'(out_m[i].size() > 0));
      chk("drop",  i, 8'(o_drop_w[i]),  8'(drop_m[i]));
      if (out_m[i].size() > 0) chk("data", i, o_data_w[i], out_m[i][0]);
    end
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) step(1'b0, 1'b1, 8'(s[k]), 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((out_m[0].size() > 0 || out_m[1].size() > 0) && n < 200) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("drain_bound", 0, 8'(n < 200), 8'd1);
  endtask

  initial begin
    logic [7:0] d;
    int sel;
    i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) chk("reset_data", i, o_data_w[i], 8'h00);

    // Basic line, edit, empty backspace, overflow on the small instance.
    send_str("ab1"); step(1'b0, 1'b1, 8'h0D, 1'b1); drain();
    send_str("xy"); step(1'b0, 1'b1, 8'h08, 1'b1); send_str("z");
    step(1'b0, 1'b1, 8'h0D, 1'b1); drain();
    step(1'b0, 1'b1, 8'h08, 1'b1); step(1'b0, 1'b1, 8'h7F, 1'b1);
    send_str("abcdef"); step(1'b0, 1'b1, 8'h0D, 1'b1); drain();
    for (int k = 0; k < 34; k++) step(1'b0, 1'b1, "x", 1'b1);
    step(1'b0, 1'b1, 8'h0D, 1'b1); drain();

    // Stall pattern during emit.
    send_str("abc"); step(1'b0, 1'b1, 8'h0D, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1); step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0); step(1'b0, 1'b0, 8'h00, 1'b1);
    drain();

    // Input during emit is dropped; reset mid-emit abandons the line.
    send_str("hello"); step(1'b0, 1'b1, 8'h0D, 1'b0);
    step(1'b0, 1'b1, "q", 1'b0); step(1'b0, 1'b1, "r", 1'b1); drain();
    send_str("wxyz"); step(1'b0, 1'b1, 8'h0D, 1'b1); step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1); step(1'b0, 1'b0, 8'h00, 1'b1);
    send_str("q"); step(1'b0, 1'b1, 8'h0D, 1'b1); drain();

    // Bare CR, then LF and other controls ignored.
    step(1'b0, 1'b1, 8'h0D, 1'b1); drain();
    step(1'b0, 1'b1, 8'h0A, 1'b1); step(1'b0, 1'b1, 8'h1B, 1'b1);
    step(1'b0, 1'b1, 8'h0D, 1'b1); drain();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 15));
      case (sel)
        0, 1, 2, 3, 4, 5, 6, 7: d = 8'("a" + $urandom_range(0, 25));
        8, 9:  d = 8'($urandom_range(8'h20, 8'h7E));
        10:    d = 8'h08;
        11:    d = 8'h7F;
        12:    d = 8'h0D;
        13:    d = 8'h0A;
        14:    d = 8'($urandom_range(0, 8'h1F));
        default: d = 8'($urandom_range(8'h80, 8'hFF));
      endcase
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), d,
           ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
